data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/data_mem_unit.sv | 140 ++++++++++++++
 tb/tb_data_mem_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Byte-addressed little-endian data memory with RV32I load/store sizing and a
// single-outstanding request/response handshake; response after LATENCY cycles.
module data_mem_unit #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [7:0]  mem [DEPTH_BYTES];

  logic        accept;
  logic [2:0]  size;
  logic        f3_ok;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [32:0] last_addr;
  logic [AW-1:0] idx;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] load_data;

  assign accept = req_valid && req_ready && !reset;
  assign idx    = req_addr[AW-1:0];

  // Range check is done on 33 bits so addresses near 2^32 cannot wrap back in.
  always_comb begin
    size  = 3'd1;
    f3_ok = 1'b0;
    case (req_funct3)
      3'b000: begin size = 3'd1; f3_ok = 1'b1;     end
      3'b001: begin size = 3'd2; f3_ok = 1'b1;     end
      3'b010: begin size = 3'd4; f3_ok = 1'b1;     end
      3'b100: begin size = 3'd1; f3_ok = !req_we;  end
      3'b101: begin size = 3'd2; f3_ok = !req_we;  end
      default: begin size = 3'd4; f3_ok = 1'b0;    end
    endcase
    misaligned   = ((size == 3'd2) && req_addr[0]) ||
                   ((size == 3'd4) && (req_addr[1:0] != 2'b00));
    last_addr    = {1'b0, req_addr} + {30'b0, size} - 33'd1;
    out_of_range = last_addr >= 33'(DEPTH_BYTES);
    req_err      = !f3_ok || misaligned || out_of_range;
  end

  // Byte lanes wrap within the index width; only in-range lanes are ever used.
  assign b0 = mem[idx];
  assign b1 = mem[idx + AW'(1)];
  assign b2 = mem[idx + AW'(2)];
  assign b3 = mem[idx + AW'(3)];

  always_comb begin
    load_data = 32'd0;
    case (req_funct3)
      3'b000:  load_data = {{24{b0[7]}}, b0};
      3'b001:  load_data = {{16{b1[7]}}, b1, b0};
      3'b010:  load_data = {b3, b2, b1, b0};
      3'b100:  load_data = {24'd0, b0};
      3'b101:  load_data = {16'd0, b1, b0};
      default: load_data = 32'd0;
    endcase
  end

  // Memory contents survive reset; only the handshake state is cleared.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      mem[idx] <= req_wdata[7:0];
      if (size != 3'd1) mem[idx + AW'(1)] <= req_wdata[15:8];
      if (size == 3'd4) begin
        mem[idx + AW'(2)] <= req_wdata[23:16];
        mem[idx + AW'(3)] <= req_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            rsp_err   <= req_err;
            rsp_rdata <= (req_we || req_err) ? 32'd0 : load_data;
            if (LATENCY > 1) begin
              state <= WAIT;
              cnt   <= 2'(LATENCY - 2);
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: one instance at LATENCY=1 (unit 0), one at LATENCY=3 (unit 1).
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] mref [2][1024];

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH_BYTES(1024), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_unit #(.DEPTH_BYTES(1024), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // Reference: legality from the ISA size rules, memory as a plain byte array.
  task automatic model_op(input int u, input bit we, input bit [2:0] f3,
                          input bit [31:0] addr, input bit [31:0] wd,
                          output bit [31:0] rd, output bit er);
    int n;
    longint unsigned last;
    bit [31:0] v;
    n  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    er = 1'b0;
    if (we && !(f3 inside {3'd0, 3'd1, 3'd2})) er = 1'b1;
    if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) er = 1'b1;
    if ((addr % n) != 0) er = 1'b1;
    last = {32'd0, addr} + 64'(n) - 64'd1;
    if (last >= 64'd1024) er = 1'b1;
    rd = 32'd0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < n; i++) mref[u][int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v + (32'(mref[u][int'(addr) + i]) << (8*i));
        rd = v;
        if (f3 == 3'd0 && v >= 32'd128)   rd = v + 32'hFFFF_FF00;
        if (f3 == 3'd1 && v >= 32'd32768) rd = v + 32'hFFFF_0000;
      end
    end
  endtask

  task automatic xact(input int u, input bit we, input bit [2:0] f3,
                      input bit [31:0] addr, input bit [31:0] wd,
                      input int hold, input string nm);
    bit [31:0] erd;
    bit        eer;
    int        k, lat;
    bit        busy_bad;
    lat = (u == 0) ? 1 : 3;
    model_op(u, we, f3, addr, wd, erd, eer);
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    req_valid[u] = 1'b1; rsp_ready[u] = 1'b0;
    k = 0;
    while (req_ready[u] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (req_ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_timeout u%0d: req_ready=%b expected 1", nm, u, req_ready[u]);
      req_valid[u] = 1'b0;
      return;
    end
    @(posedge clk); #1 req_valid[u] = 1'b0;
    k = 0; busy_bad = 1'b0;
    while (k < 20) begin
      @(negedge clk); k++;
      if (req_ready[u] !== 1'b0) busy_bad = 1'b1;
      if (rsp_valid[u] === 1'b1) break;
    end
    checks++;
    if (k != lat || rsp_valid[u] !== 1'b1) begin
      errors++;
      $display("FAIL %s latency u%0d: got %0d cycles (valid=%b) expected %0d", nm, u, k, rsp_valid[u], lat);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s busy_ready u%0d: req_ready went high while busy, expected 0", nm, u);
    end
    checks++;
    if (rsp_rdata[u] !== erd) begin
      errors++;
      $display("FAIL %s rdata u%0d: got %h expected %h", nm, u, rsp_rdata[u], erd);
    end
    checks++;
    if (rsp_err[u] !== eer) begin
      errors++;
      $display("FAIL %s err u%0d: got %b expected %b", nm, u, rsp_err[u], eer);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[u] !== 1'b1 || rsp_rdata[u] !== erd || rsp_err[u] !== eer || req_ready[u] !== 1'b0) begin
        errors++;
        $display("FAIL %s hold u%0d cyc%0d: valid=%b rdata=%h err=%b ready=%b expected 1/%h/%b/0",
                 nm, u, h, rsp_valid[u], rsp_rdata[u], rsp_err[u], req_ready[u], erd, eer);
      end
    end
    rsp_ready[u] = 1'b1;
    @(posedge clk); #1 rsp_ready[u] = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL %s release u%0d: valid=%b ready=%b expected 0/1", nm, u, rsp_valid[u], req_ready[u]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (rsp_valid[u] !== 1'b0 || rsp_rdata[u] !== 32'd0 || rsp_err[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs u%0d: valid=%b rdata=%h err=%b expected 0/0/0",
                 u, rsp_valid[u], rsp_rdata[u], rsp_err[u]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (req_ready[u] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready u%0d: got %b expected 1", u, req_ready[u]);
      end
    end
  endtask

  task automatic test_basic();
    xact(0, 1'b1, 3'b010, 32'h10, 32'h8899AABB, 0, "sw_0x10");
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_0x10");
    xact(0, 1'b0, 3'b000, 32'h13, 32'h0, 0, "lb_0x13");
    xact(0, 1'b0, 3'b100, 32'h13, 32'h0, 0, "lbu_0x13");
    xact(0, 1'b0, 3'b001, 32'h10, 32'h0, 0, "lh_0x10");
    xact(0, 1'b0, 3'b101, 32'h12, 32'h0, 0, "lhu_0x12");
  endtask

  task automatic test_errors();
    xact(0, 1'b1, 3'b010, 32'h0, 32'h11223344, 0, "sw_0x00");
    xact(0, 1'b0, 3'b010, 32'h11, 32'h0, 1, "lw_misaligned");
    xact(0, 1'b1, 3'b001, 32'h01, 32'hCAFEF00D, 0, "sh_misaligned");
    xact(0, 1'b0, 3'b010, 32'h3FE, 32'h0, 0, "lw_range");
    xact(0, 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 0, "lw_wrap");
    xact(0, 1'b1, 3'b100, 32'h04, 32'h5555AAAA, 0, "sbu_illegal");
    xact(0, 1'b0, 3'b011, 32'h08, 32'h0, 0, "ld_illegal");
    xact(0, 1'b0, 3'b010, 32'h0, 32'h0, 0, "lw_0x00_unchanged");
  endtask

  task automatic test_backpressure();
    xact(1, 1'b1, 3'b010, 32'h10, 32'h8899AABB, 0, "l3_sw");
    xact(1, 1'b0, 3'b010, 32'h10, 32'h0, 5, "l3_lw_bp");
  endtask

  task automatic test_reset_mid();
    bit [31:0] erd;
    bit        eer;
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    req_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_wait: valid=%b ready=%b expected 0/0", rsp_valid[1], req_ready[1]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_after cyc%0d: valid=%b ready=%b expected 0/1", c, rsp_valid[1], req_ready[1]);
      end
    end
    rsp_ready[1] = 1'b0;
    model_op(1, 1'b0, 3'b010, 32'h10, 32'h0, erd, eer);
    xact(1, 1'b0, 3'b010, 32'h10, 32'h0, 0, "rstmid_reread");
  endtask

  task automatic test_reset_accept();
    xact(0, 1'b1, 3'b010, 32'h20, 32'h01234567, 0, "sw_0x20");
    @(negedge clk);
    reset = 1'b1;
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    req_valid[0] = 1'b1;
    @(negedge clk);
    reset = 1'b0; req_valid[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (rsp_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL rstacc_novalid cyc%0d: got %b expected 0", c, rsp_valid[0]);
      end
      @(negedge clk);
    end
    xact(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, "rstacc_reread");
  endtask

  task automatic test_random();
    int r;
    bit [31:0] a;
    for (int u = 0; u < 2; u++) begin
      for (int w = 0; w < 16; w++) xact(u, 1'b1, 3'b010, 32'(4*w), $urandom, 0, "rnd_init");
      for (int w = 254; w < 256; w++) xact(u, 1'b1, 3'b010, 32'(4*w), $urandom, 0, "rnd_init_hi");
    end
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'($urandom_range(0, 63));
      else if (r == 8) a = 32'(1016 + $urandom_range(0, 15));
      else             a = $urandom;
      xact(t % 2, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
           $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0;
      rsp_ready[u] = 1'b0;
    end
    test_reset();
    test_basic();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_reset_accept();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
